strum_event_queue: RTL and testbench
====================================

Name: strum_event_queue

Overview:
- Sits directly downstream of the PS/2 guitar controller poller and consumes its `keys[7:0]` vector.
- Synchronizes and debounces each key, then detects strum rising edges.
- On each strum, captures the fret chord held at that moment into a small FIFO; game/scoring logic pops events with valid/ready.
- Also emits one-cycle start/select press pulses and a live held-frets vector.

Parameters:
- DEBOUNCE_CYCLES, 2000: consecutive mismatch cycles required before a debounced key changes (4 ms at 500 kHz).
- CNT_W, 12: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- DEPTH, 4: event FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock; same clock as the poller.
- reset  in  1  synchronous, active-high reset.
- keys  in  8  from poller, active-high pressed: [0] select, [1] start, [2] strum, [3] orange, [4] blue, [5] yellow, [6] red, [7] green.
- evt_ready  in  1  consumer accepts the head event this cycle.
- overflow_clear  in  1  clears evt_overflow.
- evt_valid  out  1  FIFO non-empty.
- evt_frets  out  5  head event chord: [0] green, [1] red, [2] yellow, [3] blue, [4] orange.
- evt_overflow  out  1  sticky; an event was dropped.
- frets_held  out  5  current debounced frets, same bit mapping as evt_frets.
- start_pulse  out  1  one-cycle pulse on debounced start press.
- select_pulse  out  1  one-cycle pulse on debounced select press.

Behaviour:
- Reset (synchronous, active-high) clears everything to 0:
  - sync flops, debounced regs `deb`, previous regs `deb_prev`, counters;
  - FIFO pointers and count;
  - all outputs.
- Keys are treated as released after reset.
- Synchronizer: 2-flop per bit, `sync2` = keys delayed by 2 edges.
- Debounce, per bit i:
  - if `sync2[i]==deb[i]`: counter cleared to 0;
  - else: counter increments;
  - on the edge where a mismatch is present and counter == DEBOUNCE_CYCLES-1: `deb[i]<=sync2[i]` and counter <= 0;
  - net effect: `deb` changes after DEBOUNCE_CYCLES consecutive mismatch edges; any match resets the count.
- Edge detect:
  - `deb_prev<=deb` every cycle;
  - `rise = deb & ~deb_prev`, combinational.
- Pulses: `start_pulse = rise[1]` and `select_pulse = rise[0]`, registered, so exactly one cycle wide.
- `frets_held` is registered from `deb` with the mapping above.
- Push: `rise[2]` pushes `{deb[3],deb[4],deb[5],deb[6],deb[7]}` (orange..green → [4]..[0]). The chord is the current debounced fret state in the strum-edge cycle.
- FIFO:
  - show-ahead: `evt_frets` = head entry whenever `evt_valid`;
  - pop when `evt_valid && evt_ready`;
  - `evt_valid` is a registered `count!=0`; a push into an empty FIFO makes `evt_valid` high on the next edge.
  - When `evt_valid=0`, `evt_frets` holds its last value (don't-care for checkers).
- Boundaries:
  - push and pop on empty: push only (pop ignored).
  - push and pop when full: both occur; count stays DEPTH; no overflow.
  - push when full, no pop: event dropped; `evt_overflow<=1`; FIFO unchanged.
  - `overflow_clear` in the same cycle as a new drop: overflow stays 1.
  - pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Reset mid-operation: queued events are discarded and `evt_valid` drops on the reset edge. A key held through reset re-debounces as a fresh press: strum held produces one event DEBOUNCE_CYCLES+3 edges after reset deasserts.
- Latency: a key change stable from edge t0 reaches `deb` after edge t0+DEBOUNCE_CYCLES+1. A strum press produces `evt_valid=1` after the (DEBOUNCE_CYCLES+3)th edge following the change.

Test Plan:
- Reset with keys=8'hFF held, evt_ready=0 → during reset all outputs 0. After release with DEBOUNCE_CYCLES=4, exactly one event, evt_frets=5'b11111, start_pulse and select_pulse each high for 1 cycle.
- DEBOUNCE_CYCLES=4, keys 0→8'h84 held → evt_valid rises after 7th edge, evt_frets=5'b00001. evt_ready=1 for one cycle → evt_valid=0 next cycle.
- Bounce: strum high 3 cycles, low 1, high 3, low → no event, frets_held unchanged. Strum held 4+ cycles → exactly one event.
- evt_ready=0, five strums with chords 5'h01, 02, 04, 08, 10 → evt_overflow=1. Draining yields 01, 02, 04, 08 in order, then evt_valid=0. overflow_clear → evt_overflow=0.
- FIFO full (4 entries), strum edge coincides with evt_ready=1 → head popped, new chord appended at tail, count=4, evt_overflow stays 0.
- 3 events queued, assert reset 1 cycle → evt_valid=0 next cycle, no stale events after reset with keys=0.

Source files
------------

// File: rtl/strum_event_queue.sv
// strum_event_queue: synchronizes and debounces the guitar key vector, turns strum
//   presses into fret-chord events held in a small FIFO, and emits start/select pulses.
// Ports: clk/reset (sync, active-high); keys from the poller; evt_valid/evt_ready/evt_frets
//   event stream with sticky evt_overflow (cleared by overflow_clear); frets_held; start/select pulses.
// Latency: key change -> deb after DEBOUNCE_CYCLES+1 edges; strum press -> evt_valid after DEBOUNCE_CYCLES+3 edges.
// Backpressure: events wait in a DEPTH-entry FIFO; a strum arriving while full with no pop is dropped and flagged.

// sevq_fifo: show-ahead FIFO with registered non-empty flag and drop indication.
// Latency: push -> out_vld on the same edge the entry is written; head data is combinational from storage.
// Backpressure: push while full is accepted only if the head is popped in the same cycle, else drop=1.
module sevq_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  output logic         drop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          full;
  logic          pop;
  logic          push;

  assign full = (count == (AW+1)'(DEPTH));
  // out_vld mirrors count!=0, so it is a safe pop qualifier.
  assign pop  = out_vld && pop_rdy;
  // When full, a simultaneous pop frees the head slot, which is exactly wr_ptr.
  assign push = push_vld && (!full || pop);
  assign drop = push_vld && full && !pop;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + (AW+1)'(1);
    else if (pop && !push)
      count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      out_vld <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count   <= count_nxt;
      out_vld <= (count_nxt != '0);
    end
  end

  assign out_dat = mem[rd_ptr];
endmodule

module strum_event_queue #(
  parameter int DEBOUNCE_CYCLES = 2000,
  parameter int CNT_W           = 12,
  parameter int DEPTH           = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keys,
  input  logic       evt_ready,
  input  logic       overflow_clear,
  output logic       evt_valid,
  output logic [4:0] evt_frets,
  output logic       evt_overflow,
  output logic [4:0] frets_held,
  output logic       start_pulse,
  output logic       select_pulse
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       deb;
  logic [7:0]       deb_prev;
  logic [7:0]       rise;
  logic [CNT_W-1:0] cnt [8];
  logic [4:0]       chord;
  logic             fifo_drop;

  // Two-flop synchronizer; cleared by reset so held keys look released afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  // Per-key debounce: deb follows sync2 only after DEBOUNCE_CYCLES consecutive
  // mismatching edges; any matching edge restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      deb_prev <= deb;
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise  = deb & ~deb_prev;
  // Fret reorder: orange..green -> [4]..[0].
  assign chord = {deb[3], deb[4], deb[5], deb[6], deb[7]};

  always_ff @(posedge clk) begin
    if (reset) begin
      frets_held   <= '0;
      start_pulse  <= 1'b0;
      select_pulse <= 1'b0;
      evt_overflow <= 1'b0;
    end else begin
      frets_held   <= chord;
      start_pulse  <= rise[1];
      select_pulse <= rise[0];
      // A new drop wins over a clear in the same cycle.
      if (fifo_drop)
        evt_overflow <= 1'b1;
      else if (overflow_clear)
        evt_overflow <= 1'b0;
    end
  end

  sevq_fifo #(
    .W     (5),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (rise[2]),
    .push_dat (chord),
    .pop_rdy  (evt_ready),
    .out_vld  (evt_valid),
    .out_dat  (evt_frets),
    .drop     (fifo_drop)
  );
endmodule

// File: tb/tb_strum_event_queue.sv
module tb_strum_event_queue;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] keys = 8'hFF;
  logic       evt_ready = 1'b0;
  logic       overflow_clear = 1'b0;
  logic       evt_valid;
  logic [4:0] evt_frets;
  logic       evt_overflow;
  logic [4:0] frets_held;
  logic       start_pulse;
  logic       select_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  strum_event_queue #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (3),
    .DEPTH           (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .keys           (keys),
    .evt_ready      (evt_ready),
    .overflow_clear (overflow_clear),
    .evt_valid      (evt_valid),
    .evt_frets      (evt_frets),
    .evt_overflow   (evt_overflow),
    .frets_held     (frets_held),
    .start_pulse    (start_pulse),
    .select_pulse   (select_pulse)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: keys pass a 2-stage delay; a debounced key flips when the
  // last DEB delayed samples all disagree with it; events are a plain queue.
  logic [7:0] m_s1, m_s2, m_deb, m_prev;
  logic [7:0] hist[$];
  logic [4:0] q[$];
  logic       m_valid, m_ov, m_start, m_select;
  logic [4:0] m_held;
  logic [7:0] t_rise, t_deb;
  logic [4:0] t_chord;
  logic       t_pop, t_full, t_drop, t_all;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0;
        hist.delete();
        q.delete();
        m_valid = 1'b0; m_ov = 1'b0; m_start = 1'b0; m_select = 1'b0; m_held = '0;
      end else begin
        t_rise  = m_deb & ~m_prev;
        t_chord = {m_deb[3], m_deb[4], m_deb[5], m_deb[6], m_deb[7]};
        t_pop   = (q.size() != 0) && evt_ready;
        t_full  = (q.size() == DEPTH);
        t_drop  = t_rise[2] && t_full && !t_pop;
        if (t_pop) void'(q.pop_front());
        if (t_rise[2] && !t_drop) q.push_back(t_chord);
        if (t_drop) m_ov = 1'b1;
        else if (overflow_clear) m_ov = 1'b0;
        m_valid  = (q.size() != 0);
        m_start  = t_rise[1];
        m_select = t_rise[0];
        m_held   = t_chord;
        hist.push_back(m_s2);
        while (hist.size() > DEB) void'(hist.pop_front());
        t_deb = m_deb;
        if (hist.size() == DEB) begin
          for (int i = 0; i < 8; i++) begin
            t_all = 1'b1;
            foreach (hist[k]) if (hist[k][i] == m_deb[i]) t_all = 1'b0;
            if (t_all) t_deb[i] = ~m_deb[i];
          end
        end
        m_prev = m_deb;
        m_deb  = t_deb;
        m_s2   = m_s1;
        m_s1   = keys;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cmp_evt_valid",    8'(evt_valid),    8'(m_valid));
      chk("cmp_evt_overflow", 8'(evt_overflow), 8'(m_ov));
      chk("cmp_frets_held",   8'(frets_held),   8'(m_held));
      chk("cmp_start_pulse",  8'(start_pulse),  8'(m_start));
      chk("cmp_select_pulse", 8'(select_pulse), 8'(m_select));
      if (m_valid && q.size() != 0)
        chk("cmp_evt_frets", 8'(evt_frets), 8'(q[0]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] chord_keys(input logic [4:0] c);
    return {c[0], c[1], c[2], c[3], c[4], 3'b000};
  endfunction

  task automatic strum(input logic [4:0] c);
    keys = chord_keys(c) | 8'h04;
    step(8);
    keys = 8'h00;
    step(8);
  endtask

  task automatic pop_check(input string nm, input logic [4:0] e);
    chk({nm, "_valid"}, 8'(evt_valid), 8'h01);
    chk({nm, "_frets"}, 8'(evt_frets), 8'(e));
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
  endtask

  initial begin
    // Reset with every key held: outputs cleared, then one fresh event.
    step(3);
    chk("rst_evt_valid",    8'(evt_valid),    8'h00);
    chk("rst_evt_frets",    8'(evt_frets),    8'h00);
    chk("rst_evt_overflow", 8'(evt_overflow), 8'h00);
    chk("rst_frets_held",   8'(frets_held),   8'h00);
    chk("rst_start_pulse",  8'(start_pulse),  8'h00);
    chk("rst_select_pulse", 8'(select_pulse), 8'h00);
    reset = 1'b0;
    step(6);
    chk("held_edge6_valid", 8'(evt_valid), 8'h00);
    step(1);
    chk("held_edge7_valid",  8'(evt_valid),    8'h01);
    chk("held_edge7_frets",  8'(evt_frets),    8'h1F);
    chk("held_edge7_start",  8'(start_pulse),  8'h01);
    chk("held_edge7_select", 8'(select_pulse), 8'h01);
    chk("held_edge7_held",   8'(frets_held),   8'h1F);
    step(1);
    chk("held_edge8_start",  8'(start_pulse),  8'h00);
    chk("held_edge8_select", 8'(select_pulse), 8'h00);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("held_popped_valid", 8'(evt_valid), 8'h00);
    keys = 8'h00;
    step(10);
    chk("held_single_event", 8'(evt_valid), 8'h00);

    // Strum + green: event after the 7th edge.
    keys = 8'h84;
    step(6);
    chk("green_edge6_valid", 8'(evt_valid), 8'h00);
    step(1);
    chk("green_edge7_valid", 8'(evt_valid),  8'h01);
    chk("green_edge7_frets", 8'(evt_frets),  8'h01);
    chk("green_edge7_held",  8'(frets_held), 8'h01);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("green_popped_valid", 8'(evt_valid), 8'h00);
    keys = 8'h00;
    step(10);

    // Bouncing strum never reaches DEB consecutive samples.
    keys = 8'h04; step(3);
    keys = 8'h00; step(1);
    keys = 8'h04; step(3);
    keys = 8'h00; step(10);
    chk("bounce_no_event", 8'(evt_valid),  8'h00);
    chk("bounce_held",     8'(frets_held), 8'h00);
    keys = 8'h04; step(8);
    keys = 8'h00;
    chk("clean_strum_valid", 8'(evt_valid), 8'h01);
    chk("clean_strum_frets", 8'(evt_frets), 8'h00);
    evt_ready = 1'b1; step(1); evt_ready = 1'b0;
    step(10);
    chk("clean_strum_single", 8'(evt_valid), 8'h00);

    // Overflow: fifth strum dropped while overflow_clear hits the drop cycle.
    strum(5'h01); strum(5'h02); strum(5'h04); strum(5'h08);
    chk("full_no_overflow", 8'(evt_overflow), 8'h00);
    keys = chord_keys(5'h10) | 8'h04;
    step(6);
    overflow_clear = 1'b1;
    step(1);
    overflow_clear = 1'b0;
    chk("drop_beats_clear", 8'(evt_overflow), 8'h01);
    step(1);
    keys = 8'h00;
    step(8);
    chk("overflow_sticky", 8'(evt_overflow), 8'h01);
    pop_check("drain0", 5'h01);
    pop_check("drain1", 5'h02);
    pop_check("drain2", 5'h04);
    pop_check("drain3", 5'h08);
    chk("drained_valid", 8'(evt_valid), 8'h00);
    overflow_clear = 1'b1;
    step(1);
    overflow_clear = 1'b0;
    chk("overflow_cleared", 8'(evt_overflow), 8'h00);

    // Full FIFO with pop coinciding with the push: head leaves, new tail enters.
    strum(5'h03); strum(5'h05); strum(5'h06); strum(5'h09);
    keys = chord_keys(5'h0A) | 8'h04;
    step(6);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    step(1);
    keys = 8'h00;
    step(8);
    chk("pushpop_full_overflow", 8'(evt_overflow), 8'h00);
    pop_check("pp0", 5'h05);
    pop_check("pp1", 5'h06);
    pop_check("pp2", 5'h09);
    pop_check("pp3", 5'h0A);
    chk("pp_drained_valid", 8'(evt_valid), 8'h00);

    // Reset mid-operation discards queued events.
    strum(5'h01); strum(5'h02); strum(5'h04);
    chk("pre_reset_valid", 8'(evt_valid), 8'h01);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("reset_drops_valid", 8'(evt_valid), 8'h00);
    step(20);
    chk("no_stale_events", 8'(evt_valid), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
